// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package ifetch_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam int IBUF_DEPTH      = 2;
    localparam int PC_STEP         = 4;
    localparam int DEF_INS_ADDRESS = 9;
    localparam int DEF_INS_W       = 32;

    // Buffer entry at the default widths; the buffer declares its own copy sized to its parameters.
    typedef struct packed {
        logic [DEF_INS_ADDRESS-1:0] pc;
        logic [DEF_INS_W-1:0]       inst;
    } ibuf_entry_t;

endpackage

// File: rtl/ifetch_buf.sv
// Small in-order FIFO holding fetched {pc, instruction} pairs for decode.
module ifetch_buf
    import ifetch_pkg::*;
#(
    parameter int AW = 9,
    parameter int DW = 32,
    parameter int CW = $clog2(IBUF_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [AW-1:0] push_pc,
    input  logic [DW-1:0] push_inst,
    output logic [CW-1:0] count,
    output logic [AW-1:0] head_pc,
    output logic [DW-1:0] head_inst
);

    localparam int PW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [DW-1:0] inst;
    } entry_t;

    entry_t        mem_reg [IBUF_DEPTH];
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;

    // Data slots need no reset: count gates visibility of their contents.
    generate
        for (genvar gi = 0; gi < IBUF_DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == PW'(gi))) begin
                    mem_reg[gi] <= '{pc: push_pc, inst: push_inst};
                end
            end
        end
    endgenerate

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign count     = count_reg;
    assign head_pc   = mem_reg[rd_ptr_reg].pc;
    assign head_inst = mem_reg[rd_ptr_reg].inst;

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch controller: PC, run/halt FSM, redirect handling and delivery counter.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int INS_ADDRESS = 9,
    parameter int INS_W       = 32,
    parameter int RESET_PC    = 0,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [INS_ADDRESS-1:0] imem_ra,
    input  logic [INS_W-1:0]       imem_rd,
    input  logic                   redirect_valid,
    input  logic [INS_ADDRESS-1:0] redirect_pc,
    input  logic                   halt_req,
    output logic                   if_valid,
    input  logic                   if_ready,
    output logic [INS_W-1:0]       if_inst,
    output logic [INS_ADDRESS-1:0] if_pc,
    output logic                   halted,
    output logic [CNT_W-1:0]       deliv_cnt
);

    localparam int BCW = $clog2(IBUF_DEPTH + 1);

    state_t                 state_reg;
    state_t                 state_next;
    logic                   halted_reg;
    logic [INS_ADDRESS-1:0] pc_reg;
    logic [INS_ADDRESS-1:0] pc_next;
    logic [CNT_W-1:0]       deliv_cnt_reg;
    logic [BCW-1:0]         buf_count;
    logic                   push;
    logic                   pop;

    assign if_valid = (buf_count != '0);
    assign pop      = if_valid && if_ready;
    assign push     = (state_reg == RUN) && !redirect_valid
                      && ((buf_count < BCW'(IBUF_DEPTH)) || pop);

    // Redirect wins over sequential fetch; addition wraps modulo the address space.
    always_comb begin
        pc_next = pc_reg;
        if (redirect_valid) begin
            pc_next = {redirect_pc[INS_ADDRESS-1:2], 2'b00};
        end else if (push) begin
            pc_next = pc_reg + INS_ADDRESS'(PC_STEP);
        end
    end

    // halt_req dominates a same-cycle redirect; a lone redirect resumes fetching.
    always_comb begin
        state_next = state_reg;
        if (halt_req) begin
            state_next = HALT;
        end else if (redirect_valid) begin
            state_next = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= RUN;
            halted_reg    <= 1'b0;
            pc_reg        <= INS_ADDRESS'(RESET_PC);
            deliv_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            halted_reg <= (state_next == HALT);
            pc_reg     <= pc_next;
            if (pop && (deliv_cnt_reg != '1)) begin
                deliv_cnt_reg <= deliv_cnt_reg + CNT_W'(1);
            end
        end
    end

    ifetch_buf #(
        .AW (INS_ADDRESS),
        .DW (INS_W),
        .CW (BCW)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .flush     (redirect_valid),
        .push_pc   (pc_reg),
        .push_inst (imem_rd),
        .count     (buf_count),
        .head_pc   (if_pc),
        .head_inst (if_inst)
    );

    assign imem_ra   = pc_reg;
    assign halted    = halted_reg;
    assign deliv_cnt = deliv_cnt_reg;

endmodule
